// File: rtl/fifo_send_reader.sv
// fifo_send_reader: pops 32-bit words from a prefetch FIFO and streams them out as a length-bounded byte packet
module fifo_send_reader #(
  parameter int LEN_W     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  output logic             busy,
  output logic             done,
  output logic             fifo_rd_en,
  input  logic             fifo_rd_vld,
  input  logic [31:0]      fifo_rd_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic [15:0]      starve_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT_WORD, SEND, DONE} state_t;
  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_rem;
  logic [31:0]      r_hold;
  logic [1:0]       r_idx, w_sel;
  logic [15:0]      r_starve;
  logic             w_hs, w_final, w_word_end, w_pop;
  always_ff @(posedge rd_clk)
    if (rd_rst) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start) w_next = (pkt_len != '0) ? WAIT_WORD : DONE;
      WAIT_WORD: if (fifo_rd_vld) w_next = SEND;
      SEND:      if (w_hs) w_next = w_final ? DONE : (w_word_end && !fifo_rd_vld) ? WAIT_WORD : SEND;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    w_hs       = (r_state == SEND) && tx_ready;
    w_final    = w_hs && (r_rem == LEN_W'(1));
    w_word_end = w_hs && (r_idx == 2'd3);
    // the next word is fetched on the same edge the last byte of the held word leaves
    w_pop      = !rd_rst && fifo_rd_vld && ((r_state == WAIT_WORD) || (w_word_end && !w_final));
    fifo_rd_en = w_pop;
    busy       = (r_state == WAIT_WORD) || (r_state == SEND);
    done       = r_state == DONE;
    tx_valid   = r_state == SEND;
    tx_last    = tx_valid && (r_rem == LEN_W'(1));
    w_sel      = LSB_FIRST ? r_idx : ~r_idx;
    tx_data    = tx_valid ? r_hold[{w_sel, 3'b000} +: 8] : 8'h00;
    starve_cnt = r_starve;
  end
  always_ff @(posedge rd_clk)
    if (rd_rst) begin
      r_rem    <= '0;
      r_hold   <= '0;
      r_idx    <= '0;
      r_starve <= '0;
    end else begin
      if (r_state == IDLE && start) r_rem <= pkt_len;
      else if (w_hs)                r_rem <= r_rem - LEN_W'(1);
      if (w_pop) begin
        r_hold <= fifo_rd_data;
        r_idx  <= 2'd0;
      end else if (w_hs) r_idx <= r_idx + 2'd1;
      if (r_state == WAIT_WORD && !fifo_rd_vld && r_starve != 16'hFFFF) r_starve <= r_starve + 16'd1;
    end
endmodule

// File: tb/tb_fifo_send_reader.sv
// tb_fifo_send_reader: directed packets against a queue-based byte-stream model
module tb_fifo_send_reader;
  logic        clk = 0;
  logic        rd_rst = 1, start = 0, fifo_rd_vld = 0, tx_ready = 1;
  logic [15:0] pkt_len = 0;
  logic [31:0] fifo_rd_data = 0;
  logic        busy, done, fifo_rd_en, tx_valid, tx_last;
  logic [7:0]  tx_data;
  logic [15:0] starve_cnt;
  always #5 clk = ~clk;
  fifo_send_reader dut (
    .rd_clk(clk), .rd_rst(rd_rst), .start(start), .pkt_len(pkt_len), .busy(busy), .done(done),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .starve_cnt(starve_cnt)
  );
  int total = 0, bad = 0;
  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$], log_q[$];
  bit          vld_block = 0, rdy_toggle = 0, pop_pend = 0, prev_stall = 0, prev_wpop = 0;
  int          pops = 0, done_cnt = 0, valid_cnt = 0, hs_cnt = 0, cyc = 0, first_hs = -1, last_hs = -1, exp_starve = 0;
  logic [7:0]  prev_data = 0, last_byte = 0;
  logic        prev_last = 0;
  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // Monitor: checks outputs mid-cycle and records what the next rising edge will consume
  always @(negedge clk) begin
    cyc++;
    if (rd_rst) begin
      exp_q.delete();
      exp_starve = 0;
      prev_stall = 0;
      prev_wpop  = 0;
      pop_pend   = 0;
    end else begin
      chk(starve_cnt == 16'(exp_starve), "starve_cnt", starve_cnt, exp_starve);
      chk(!(fifo_rd_en && (!fifo_rd_vld || !busy)), "rd_en_gate", fifo_rd_en, 0);
      chk(!(done && busy), "done_busy", busy, 0);
      if (prev_wpop) chk(tx_valid, "pop_latency", tx_valid, 1);
      if (prev_stall && tx_valid) begin
        chk(tx_data == prev_data, "stall_data", tx_data, prev_data);
        chk(tx_last == prev_last, "stall_last", tx_last, prev_last);
      end
      if (tx_valid) begin
        valid_cnt++;
        chk(exp_q.size() != 0, "extra_byte", tx_data, 0);
        if (exp_q.size() != 0) begin
          chk(tx_data == exp_q[0], "tx_data", tx_data, exp_q[0]);
          chk(tx_last == (exp_q.size() == 1), "tx_last", tx_last, exp_q.size() == 1);
        end
      end
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        log_q.push_back(tx_data);
        if (tx_last) last_byte = tx_data;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (done) done_cnt++;
      if (busy && !tx_valid && !fifo_rd_vld && exp_starve < 65535) exp_starve++;
      prev_wpop  = fifo_rd_en && !tx_valid;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
      pop_pend   = fifo_rd_en;
    end
  end
  // FIFO and sink driver: applies the pop seen last edge, then presents the next head word
  always @(posedge clk) begin
    #2;
    if (pop_pend) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
      pop_pend = 0;
    end
    fifo_rd_vld  = (fifo_q.size() != 0) && !vld_block;
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    tx_ready     = rdy_toggle ? !tx_ready : 1'b1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int len, input int nw, input logic [31:0] w0, input logic [31:0] w1,
                      input bit tog, input int exp_pops, input int starve);
    int t;
    logic [31:0] w;
    pops = 0; done_cnt = 0; valid_cnt = 0; hs_cnt = 0; first_hs = -1; last_hs = -1;
    log_q.delete();
    if (nw > 0) fifo_q.push_back(w0);
    if (nw > 1) fifo_q.push_back(w1);
    for (int i = 0; i < len; i++) begin
      w = (i < 4) ? w0 : w1;
      exp_q.push_back(8'(w >> (8 * (i % 4))));
    end
    rdy_toggle = tog;
    vld_block  = starve > 0;
    pkt_len    = 16'(len);
    start      = 1;
    tick;
    start   = 0;
    pkt_len = 16'($urandom);
    if (starve > 0) begin
      repeat (starve) tick;
      vld_block = 0;
    end
    t = 0;
    while (done_cnt == 0 && t < 60) begin
      tick;
      t++;
      start   = (t == 3) && busy;
      pkt_len = 16'($urandom);
    end
    start = 0;
    chk(done_cnt == 1, "done_seen", done_cnt, 1);
    if (len == 0) chk(t <= 2, "done_latency", t, 2);
    repeat (4) tick;
    chk(done_cnt == 1, "one_done", done_cnt, 1);
    chk(pops == exp_pops, "pops", pops, exp_pops);
    chk(exp_q.size() == 0, "bytes_left", exp_q.size(), 0);
    chk(hs_cnt == len, "byte_count", hs_cnt, len);
    chk(busy == 0, "idle_busy", busy, 0);
    rdy_toggle = 0;
    fifo_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int t;
    repeat (3) tick;
    chk(busy == 0 && done == 0 && tx_valid == 0 && tx_last == 0, "rst_ctrl", {busy, done, tx_valid, tx_last}, 0);
    chk(tx_data == 8'h00, "rst_data", tx_data, 0);
    chk(starve_cnt == 16'h0, "rst_starve", starve_cnt, 0);
    chk(fifo_rd_en == 0, "rst_rd_en", fifo_rd_en, 0);
    rd_rst = 0;
    tick;
    send(4, 1, 32'hDDCCBBAA, 32'h0, 0, 1, 10);
    chk(starve_cnt == 16'd10, "starve_10", starve_cnt, 10);
    chk(log_q.size() == 4 && log_q[0] == 8'hAA && log_q[3] == 8'hDD, "starve_bytes", log_q.size(), 4);
    send(8, 2, 32'h44332211, 32'h88776655, 0, 2, 0);
    chk(log_q.size() == 8 && log_q[0] == 8'h11 && log_q[7] == 8'h88, "seq8_ends", log_q.size(), 8);
    chk(last_byte == 8'h88, "seq8_last", last_byte, 8'h88);
    chk(last_hs - first_hs == 7, "seq8_back2back", last_hs - first_hs, 7);
    send(5, 2, 32'hA3A2A1A0, 32'hB3B2B1B0, 0, 2, 0);
    chk(last_byte == 8'hB0, "len5_last", last_byte, 8'hB0);
    send(8, 2, 32'h0D0C0B0A, 32'h1D1C1B1A, 1, 2, 0);
    chk(log_q.size() == 8 && log_q[4] == 8'h1A && log_q[7] == 8'h1D, "toggle_bytes", log_q.size(), 8);
    send(0, 0, 32'h0, 32'h0, 0, 0, 0);
    chk(valid_cnt == 0, "len0_no_valid", valid_cnt, 0);
    pops = 0; done_cnt = 0; hs_cnt = 0;
    fifo_q.push_back(32'h44332211);
    fifo_q.push_back(32'h88776655);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h11 * (i + 1)));
    pkt_len = 16'd8;
    start   = 1;
    tick;
    start = 0;
    t = 0;
    while (hs_cnt < 3 && t < 30) begin
      tick;
      t++;
    end
    chk(hs_cnt == 3, "rst_reach3", hs_cnt, 3);
    rd_rst = 1;
    tick;
    chk(busy == 0 && done == 0 && tx_valid == 0 && tx_last == 0, "mid_rst_ctrl", {busy, done, tx_valid, tx_last}, 0);
    chk(tx_data == 8'h00 && starve_cnt == 16'h0, "mid_rst_data", {tx_data, starve_cnt}, 0);
    chk(fifo_rd_en == 0, "mid_rst_rd_en", fifo_rd_en, 0);
    rd_rst = 0;
    repeat (6) tick;
    chk(done_cnt == 0, "mid_rst_no_done", done_cnt, 0);
    chk(pops == 1 && fifo_q.size() == 1, "mid_rst_no_pop", pops, 1);
    chk(tx_valid == 0 && busy == 0, "mid_rst_idle", {tx_valid, busy}, 0);
    fifo_q.delete();
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
